demux_reg_16b_8output: RTL

DEMUX_REG_16B_8OUTPUT -- requirements
Module: demux_reg_16b_8output

---
 rtl/demux_reg_16b_8output_pkg.sv | 25 ++
 rtl/demux_reg_16b_8output_reg_16b.sv | 27 ++
 rtl/demux_reg_16b_8output.sv | 99 +++++++++
 3 files changed

// File: rtl/demux_reg_16b_8output_pkg.sv
// Purpose: project constants shared by the mux, ALU and register demux.
// Latency: none; this file holds only constants and types.
// Backpressure: none; there is no flow control in these definitions.
package demux_reg_16b_8output_pkg;

    // Datapath width used by the mux, ALU and register demux.
    localparam int DATA_W  = 16;
    // Select / pointer width. The number of destinations is 2**SEL_W.
    localparam int SEL_W   = 3;
    localparam int NUM_OUT = 1 << SEL_W;

    // Op encodings. The mux uses the same codes, which makes the demux its
    // exact inverse: a value written with Op=k appears at mux input k.
    typedef enum logic [SEL_W-1:0] {
        OP_A = 3'b000,
        OP_B = 3'b001,
        OP_C = 3'b010,
        OP_D = 3'b011,
        OP_E = 3'b100,
        OP_F = 3'b101,
        OP_G = 3'b110,
        OP_H = 3'b111
    } op_e;

endpackage

// File: rtl/demux_reg_16b_8output_reg_16b.sv
// Purpose: one data register with load enable and async active-high reset.
// Latency: 1 cycle from i_ld to o_q.
// Backpressure: none; a load is always accepted.
module reg_16b #(
    parameter int W = 16
) (
    input  logic         i_clk,
    input  logic         i_rst,
    input  logic         i_ld,
    input  logic [W-1:0] i_d,
    output logic [W-1:0] o_q
);

    logic [W-1:0] r_q;

    // Capture i_d on a load. Otherwise hold the value. Reset clears it immediately.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_q <= '0;
        end else if (i_ld) begin
            r_q <= i_d;
        end
    end

    assign o_q = r_q;

endmodule

// File: rtl/demux_reg_16b_8output.sv
// Purpose: write-side demux into eight registers. It has direct (Op) and auto-increment (Ptr) modes.
// Latency: 1 cycle from the Wr edge to the register and Valid outputs. Full is combinational from Valid.
// Backpressure: none; every write is accepted, and Clr wins over Wr in the same cycle.
module demux_reg_16b_8output #(
    parameter int DATA_W = demux_reg_16b_8output_pkg::DATA_W,
    parameter int SEL_W  = demux_reg_16b_8output_pkg::SEL_W
) (
    input  logic                    CLK,
    input  logic                    Reset,
    input  logic [DATA_W-1:0]       In,
    input  logic [SEL_W-1:0]        Op,
    input  logic                    Wr,
    input  logic                    Auto,
    input  logic                    Clr,
    output logic [DATA_W-1:0]       A,
    output logic [DATA_W-1:0]       B,
    output logic [DATA_W-1:0]       C,
    output logic [DATA_W-1:0]       D,
    output logic [DATA_W-1:0]       E,
    output logic [DATA_W-1:0]       F,
    output logic [DATA_W-1:0]       G,
    output logic [DATA_W-1:0]       H,
    output logic [(1<<SEL_W)-1:0]   Valid,
    output logic [SEL_W-1:0]        Ptr,
    output logic                    Full
);

    import demux_reg_16b_8output_pkg::*;

    localparam int N_OUT = 1 << SEL_W;

    logic [SEL_W-1:0]  w_dest;
    logic              w_wr_en;
    logic [N_OUT-1:0]  w_ld;
    logic [DATA_W-1:0] w_q [N_OUT];

    logic [N_OUT-1:0]  r_valid;
    logic [SEL_W-1:0]  r_ptr;

    // Auto mode ignores Op and writes to the pointer slot. Clr suppresses any write.
    assign w_dest  = Auto ? r_ptr : Op;
    assign w_wr_en = Wr & ~Clr;

    // Decode the destination into a one-hot load vector, so at most one register changes.
    always_comb begin
        w_ld = '0;
        if (w_wr_en) begin
            w_ld[w_dest] = 1'b1;
        end
    end

    // Eight identical storage registers, indexed by the Op encoding.
    for (genvar g = 0; g < N_OUT; g++) begin : g_reg
        reg_16b #(
            .W (DATA_W)
        ) u_reg (
            .i_clk (CLK),
            .i_rst (Reset),
            .i_ld  (w_ld[g]),
            .i_d   (In),
            .o_q   (w_q[g])
        );
    end

    // Valid bits are sticky until Clr or Reset. An overwrite leaves them set.
    always_ff @(posedge CLK or posedge Reset) begin
        if (Reset) begin
            r_valid <= '0;
        end else if (Clr) begin
            r_valid <= '0;
        end else begin
            r_valid <= r_valid | w_ld;
        end
    end

    // The pointer advances only on auto-mode writes and wraps naturally at 2**SEL_W.
    always_ff @(posedge CLK or posedge Reset) begin
        if (Reset) begin
            r_ptr <= '0;
        end else if (Clr) begin
            r_ptr <= '0;
        end else if (Wr && Auto) begin
            r_ptr <= r_ptr + SEL_W'(1);
        end
    end

    assign A     = w_q[OP_A];
    assign B     = w_q[OP_B];
    assign C     = w_q[OP_C];
    assign D     = w_q[OP_D];
    assign E     = w_q[OP_E];
    assign F     = w_q[OP_F];
    assign G     = w_q[OP_G];
    assign H     = w_q[OP_H];
    assign Valid = r_valid;
    assign Ptr   = r_ptr;
    assign Full  = &r_valid;

endmodule
